// File: rtl/sram64x8_pkg.sv
// Shared sizing and active-low idle pin levels for the 64x8 SRAM FIFO controller.
package sram64x8_pkg;
  localparam int ADDR_W     = 6;
  localparam int DATA_W     = 8;
  localparam int DEPTH      = 1 << ADDR_W;
  localparam int SKID_DEPTH = 2;

  localparam logic              CEN_IDLE  = 1'b1;
  localparam logic              GWEN_IDLE = 1'b1;
  localparam logic [DATA_W-1:0] WEN_IDLE  = '1;
endpackage

// File: rtl/sram64x8_skid_buf.sv
// 2-entry register FIFO catching SRAM Q; entry 0 is always the head.
// Push lands at the edge; head visible the cycle after; producer must reserve space.
module sram64x8_skid_buf #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             head_vld,
  output logic [1:0]       cnt
);
  import sram64x8_pkg::*;

  logic [WIDTH-1:0] ent0, ent1;
  logic [1:0]       cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ent0  <= '0;
      ent1  <= '0;
      cnt_q <= '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (cnt_q == 2'd0) ent0 <= push_data;
          else               ent1 <= push_data;
          cnt_q <= cnt_q + 2'd1;
        end
        2'b01: begin
          ent0  <= ent1;
          cnt_q <= cnt_q - 2'd1;
        end
        2'b11: begin
          // Occupancy is unchanged; the new byte goes wherever the old tail sat.
          if (cnt_q == 2'd1) begin
            ent0 <= push_data;
          end else begin
            ent0 <= ent1;
            ent1 <= push_data;
          end
        end
        default: ;
      endcase
    end
  end

  assign head_data = ent0;
  assign head_vld  = (cnt_q != 2'd0);
  assign cnt       = cnt_q;

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && !pop && cnt_q == 2'(SKID_DEPTH)));
  a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(pop && cnt_q == 2'd0));
endmodule

// File: rtl/sram64x8_fifo_ctrl.sv
// Byte FIFO on one single-port 64x8 SRAM; reads win the port, 2-cycle empty-to-out.
// in_ready drops while a read is issued or storage is full; output held until popped.
module sram64x8_fifo_ctrl #(
  parameter int ADDR_W = sram64x8_pkg::ADDR_W,
  parameter int DATA_W = sram64x8_pkg::DATA_W
) (
  input  logic              CLK,
  input  logic              RSTN,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [6:0]        count,
  output logic              sram_cen,
  output logic              sram_gwen,
  output logic [DATA_W-1:0] sram_wen,
  output logic [ADDR_W-1:0] sram_a,
  output logic [DATA_W-1:0] sram_d,
  input  logic [DATA_W-1:0] sram_q
);
  import sram64x8_pkg::*;

  localparam logic [ADDR_W:0] FULL_CNT = {1'b1, {ADDR_W{1'b0}}};

  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [ADDR_W:0]   mem_cnt;
  logic              rd_pend;
  logic [1:0]        skid_cnt;
  logic [2:0]        skid_need;
  logic              pop, rd_go, wr_go;

  assign pop       = out_valid && out_ready;
  // Space the skid buffer must hold once the in-flight read and this pop settle.
  assign skid_need = {1'b0, skid_cnt} + {2'b00, rd_pend} - {2'b00, pop};
  assign rd_go     = (mem_cnt != '0) && (skid_need < 3'(SKID_DEPTH));
  assign in_ready  = !rd_go && (mem_cnt != FULL_CNT);
  // Keep the macro deselected while reset is held even though in_ready reads 1.
  assign wr_go     = in_valid && in_ready && RSTN;

  always_comb begin
    sram_cen  = CEN_IDLE;
    sram_gwen = GWEN_IDLE;
    sram_wen  = {DATA_W{WEN_IDLE[0]}};
    sram_a    = rd_ptr;
    sram_d    = in_data;
    if (wr_go) begin
      sram_cen  = 1'b0;
      sram_gwen = 1'b0;
      sram_wen  = '0;
      sram_a    = wr_ptr;
    end else if (rd_go) begin
      sram_cen  = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      mem_cnt <= '0;
      rd_pend <= 1'b0;
    end else begin
      rd_pend <= rd_go;
      if (wr_go) wr_ptr <= wr_ptr + 1'b1;
      if (rd_go) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_go, rd_go})
        2'b10:   mem_cnt <= mem_cnt + 1'b1;
        2'b01:   mem_cnt <= mem_cnt - 1'b1;
        default: ;
      endcase
    end
  end

  sram64x8_skid_buf #(.WIDTH(DATA_W)) u_skid (
    .clk       (CLK),
    .rst_n     (RSTN),
    .push      (rd_pend),
    .push_data (sram_q),
    .pop       (pop),
    .head_data (out_data),
    .head_vld  (out_valid),
    .cnt       (skid_cnt)
  );

  assign count = 7'(mem_cnt) + 7'(rd_pend) + 7'(skid_cnt);

  a_port_excl: assert property (@(posedge CLK) disable iff (!RSTN) !(wr_go && rd_go));
endmodule

// File: tb/tb_sram64x8_fifo_ctrl.sv
// Directed vector table plus fill/drain, random scoreboard and mid-read reset sequences.
module tb_sram64x8_fifo_ctrl;
  logic       CLK = 1'b0;
  logic       RSTN;
  logic       in_valid, in_ready, out_valid, out_ready;
  logic [7:0] in_data, out_data;
  logic [6:0] count;
  logic       sram_cen, sram_gwen;
  logic [7:0] sram_wen, sram_d, sram_q;
  logic [5:0] sram_a;

  int total = 0;
  int bad   = 0;

  always #5 CLK = ~CLK;

  sram64x8_fifo_ctrl dut (
    .CLK(CLK), .RSTN(RSTN),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .count(count),
    .sram_cen(sram_cen), .sram_gwen(sram_gwen), .sram_wen(sram_wen),
    .sram_a(sram_a), .sram_d(sram_d), .sram_q(sram_q)
  );

  // Behavioural macro: Q updates only on a read, one edge after the request.
  logic [7:0] mem [64];
  always @(posedge CLK) begin
    if (!sram_cen) begin
      if (!sram_gwen) begin
        for (int b = 0; b < 8; b++)
          if (!sram_wen[b]) mem[sram_a][b] <= sram_d[b];
      end else begin
        sram_q <= mem[sram_a];
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  typedef struct {
    logic       in_valid;
    logic [7:0] in_data;
    logic       out_ready;
    logic       e_in_ready;
    logic       e_out_valid;
    logic [7:0] e_out_data;
    logic [6:0] e_count;
    logic       e_cen;
    logic       e_gwen;
    logic [5:0] e_a;
  } vec_t;

  vec_t vecs [12];
  logic [7:0] sb [$];
  logic [7:0] exp_b;
  int nxt, got, cyc;

  initial begin
    vecs[0]  = '{1'b1, 8'hA5, 1'b0, 1'b1, 1'b0, 8'h00, 7'd0, 1'b0, 1'b0, 6'd0};
    vecs[1]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 7'd1, 1'b0, 1'b1, 6'd0};
    vecs[2]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 7'd1, 1'b1, 1'b1, 6'd1};
    vecs[3]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'hA5, 7'd1, 1'b1, 1'b1, 6'd1};
    vecs[4]  = '{1'b1, 8'h3C, 1'b1, 1'b1, 1'b1, 8'hA5, 7'd1, 1'b0, 1'b0, 6'd1};
    vecs[5]  = '{1'b1, 8'h5A, 1'b1, 1'b0, 1'b0, 8'h00, 7'd1, 1'b0, 1'b1, 6'd1};
    vecs[6]  = '{1'b1, 8'h5A, 1'b1, 1'b1, 1'b0, 8'h00, 7'd1, 1'b0, 1'b0, 6'd2};
    vecs[7]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h3C, 7'd2, 1'b0, 1'b1, 6'd2};
    vecs[8]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h3C, 7'd2, 1'b1, 1'b1, 6'd3};
    vecs[9]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h3C, 7'd2, 1'b1, 1'b1, 6'd3};
    vecs[10] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h5A, 7'd1, 1'b1, 1'b1, 6'd3};
    vecs[11] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 7'd0, 1'b1, 1'b1, 6'd3};

    // Reset held with a pending write request.
    RSTN = 1'b0; in_valid = 1'b1; in_data = 8'h11; out_ready = 1'b0;
    tick(); tick();
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_cen", sram_cen, 1);
    chk("rst_gwen", sram_gwen, 1);
    chk("rst_wen", sram_wen, 8'hFF);
    chk("rst_count", count, 0);
    @(negedge CLK);
    RSTN = 1'b1; in_valid = 1'b0;
    #1;
    chk("post_rst_in_ready", in_ready, 1);
    chk("post_rst_cen", sram_cen, 1);
    chk("post_rst_count", count, 0);

    // Directed single-byte latency and interleave vectors.
    for (int i = 0; i < 12; i++) begin
      @(negedge CLK);
      in_valid = vecs[i].in_valid; in_data = vecs[i].in_data; out_ready = vecs[i].out_ready;
      #1;
      chk($sformatf("v%0d_in_ready", i), in_ready, vecs[i].e_in_ready);
      chk($sformatf("v%0d_out_valid", i), out_valid, vecs[i].e_out_valid);
      if (vecs[i].e_out_valid) chk($sformatf("v%0d_out_data", i), out_data, vecs[i].e_out_data);
      chk($sformatf("v%0d_count", i), count, vecs[i].e_count);
      chk($sformatf("v%0d_cen", i), sram_cen, vecs[i].e_cen);
      chk($sformatf("v%0d_gwen", i), sram_gwen, vecs[i].e_gwen);
      chk($sformatf("v%0d_wen", i), sram_wen, {8{vecs[i].e_gwen}});
      chk($sformatf("v%0d_a", i), sram_a, vecs[i].e_a);
      if (!vecs[i].e_cen && !vecs[i].e_gwen) chk($sformatf("v%0d_d", i), sram_d, vecs[i].in_data);
    end

    // Fill to 66 with the consumer stalled; pointers start mid-array so they wrap.
    @(negedge CLK);
    out_ready = 1'b0; nxt = 0; cyc = 0;
    while (nxt < 66 && cyc < 400) begin
      in_valid = 1'b1; in_data = 8'(nxt);
      #1;
      if (in_ready) nxt++;
      tick(); cyc++;
    end
    chk("fill_accepted", nxt, 66);
    in_data = 8'hEE;
    for (int i = 0; i < 10; i++) begin
      #1;
      chk("full_in_ready", in_ready, 0);
      chk("full_cen", sram_cen, 1);
      tick();
    end
    #1;
    chk("full_count", count, 66);
    chk("full_head", out_data, 8'h00);

    // Drain from full: ordered bytes, no bubbles.
    @(negedge CLK);
    in_valid = 1'b0; out_ready = 1'b1; got = 0; cyc = 0;
    while (got < 66 && cyc < 200) begin
      #1;
      chk("drain_valid", out_valid, 1);
      if (out_valid) begin
        chk("drain_data", out_data, 8'(got));
        got++;
      end
      tick(); cyc++;
    end
    chk("drain_got", got, 66);
    #1;
    chk("drain_count", count, 0);
    chk("drain_out_valid", out_valid, 0);

    // Random traffic against a scoreboard.
    for (int c = 0; c < 10000; c++) begin
      @(negedge CLK);
      in_valid = 1'($urandom_range(0, 1)); in_data = 8'($urandom); out_ready = 1'($urandom_range(0, 1));
      #1;
      chk("rnd_count", count, sb.size());
      chk("rnd_wr_excl", !sram_cen && !sram_gwen, in_valid && in_ready);
      chk("rnd_rd_prio", !sram_cen && sram_gwen && in_ready, 0);
      if (out_valid && out_ready) begin
        if (sb.size() == 0) chk("rnd_spurious_pop", 1, 0);
        else begin
          exp_b = sb.pop_front();
          chk("rnd_data", out_data, exp_b);
        end
      end
      if (in_valid && in_ready) sb.push_back(in_data);
    end
    @(negedge CLK);
    in_valid = 1'b0; out_ready = 1'b1; cyc = 0;
    while (sb.size() > 0 && cyc < 300) begin
      #1;
      if (out_valid) begin
        exp_b = sb.pop_front();
        chk("rnd_drain_data", out_data, exp_b);
      end
      tick(); cyc++;
    end
    chk("rnd_drain_left", sb.size(), 0);
    #1;
    chk("rnd_drain_count", count, 0);

    // Reset lands one cycle after a read is issued.
    @(negedge CLK);
    out_ready = 1'b0; in_valid = 1'b1; in_data = 8'h99;
    tick();
    in_valid = 1'b0;
    #1;
    chk("mid_read_issue", {sram_cen, sram_gwen}, 2'b01);
    tick();
    RSTN = 1'b0;
    #1;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_count", count, 0);
    tick();
    RSTN = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("post_mid_out_valid", out_valid, 0);
      chk("post_mid_count", count, 0);
      tick();
    end
    in_valid = 1'b1; in_data = 8'h42;
    #1;
    chk("post_mid_wr", {sram_cen, sram_gwen}, 2'b00);
    chk("post_mid_wr_a", sram_a, 0);
    tick();
    in_valid = 1'b0;
    #1;
    chk("post_mid_count1", count, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
